bus_cycle85: RTL and testbench

Bus-cycle sequencer for the 8085-style core: turns a single internal transfer request into the multiplexed AD-bus T-state sequence (T1, T2, wait, T3, optional T4). Sits directly upstream of the address `latch` block: its `ale` output drives the latch enable and its `ad_out` feeds the latch data input, so the latch holds A[7:0] for the rest of the cycle. It also returns read data and a completion pulse to the core's execution unit.

---
 rtl/bus85_pkg.sv | 24 ++
 rtl/bus_cycle85.sv | 184 ++++++++++++++++++
 tb/tb_bus_cycle85.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus85_pkg.sv
// Shared definitions for the 8085-style bus-cycle sequencer: T-state
// encoding and the bus cycle-type codes used by the core.
package bus85_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

  localparam logic [1:0] CYC_MR = 2'b00;
  localparam logic [1:0] CYC_MW = 2'b01;
  localparam logic [1:0] CYC_IR = 2'b10;
  localparam logic [1:0] CYC_IW = 2'b11;

  // Bit 0 of the cycle type distinguishes write (1) from read (0).
  function automatic logic cyc_is_read(input logic [1:0] cyc);
    return ~cyc[0];
  endfunction

endpackage

// File: rtl/bus_cycle85.sv
// Bus-cycle sequencer: turns one transfer request into the multiplexed
// AD-bus T-state sequence T1, T2, TW*, T3 (+T4 for opcode fetch).
// Every bus-facing output is a flop loaded from the next-state decode, so
// nothing external reaches the bus pins combinationally.
import bus85_pkg::*;

module bus_cycle85 #(
  parameter int WAITMAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  cyc,
  input  logic        fetch,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        ready,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        io_m,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAITMAX);

  state_t      state_q, state_d;
  logic [1:0]  cyc_q, cyc_d;
  logic        fetch_q, fetch_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_flag_q, err_flag_d;

  logic [7:0]  ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic        ale_q, ale_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        io_m_q, io_m_d;
  logic        busy_q, busy_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        last_state;
  logic        accept;
  logic        data_phase;
  logic        read_d;

  // Next-state, capture and registered-output decode for the T-state sequence.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    fetch_d    = fetch_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    err_flag_d = err_flag_q;
    rdata_d    = rdata_q;

    last_state = (state_q == ST_T3 && !fetch_q) || (state_q == ST_T4);
    accept     = req && ((state_q == ST_IDLE) || last_state);

    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_T1: begin
        state_d    = ST_T2;
        wait_cnt_d = 8'd0;
        err_flag_d = 1'b0;
      end
      ST_T2, ST_TW: begin
        if (ready) begin
          state_d = ST_T3;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
          state_d    = ST_TW;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = ST_T3;
          err_flag_d = 1'b1;
        end
      end
      ST_T3: begin
        state_d = fetch_q ? ST_T4 : ST_IDLE;
        if (cyc_is_read(cyc_q)) begin
          rdata_d = ad_in;
        end
      end
      ST_T4:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d    = ST_T1;
      cyc_d      = cyc;
      fetch_d    = fetch && (cyc == CYC_MR);
      wdata_d    = wdata;
      err_flag_d = 1'b0;
    end

    done_d = last_state;
    err_d  = last_state && err_flag_q;

    data_phase = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
    read_d     = cyc_is_read(cyc_d);

    ale_d   = (state_d == ST_T1);
    busy_d  = (state_d != ST_IDLE);
    rd_n_d  = !(data_phase && read_d);
    wr_n_d  = !(data_phase && !read_d);
    ad_oe_d = (state_d == ST_T1) || (data_phase && !read_d);

    ad_out_d = ad_out_q;
    a_hi_d   = a_hi_q;
    io_m_d   = io_m_q;
    if (state_d == ST_T1) begin
      ad_out_d = addr[7:0];
      a_hi_d   = addr[15:8];
      io_m_d   = cyc[1];
    end else if (data_phase && !read_d) begin
      ad_out_d = wdata_d;
    end
  end

  // State, captured request fields and bus output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= CYC_MR;
      fetch_q    <= 1'b0;
      wdata_q    <= 8'h00;
      wait_cnt_q <= 8'd0;
      err_flag_q <= 1'b0;
      ad_out_q   <= 8'h00;
      ad_oe_q    <= 1'b0;
      a_hi_q     <= 8'h00;
      ale_q      <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      io_m_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      fetch_q    <= fetch_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      err_flag_q <= err_flag_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      a_hi_q     <= a_hi_d;
      ale_q      <= ale_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      io_m_q     <= io_m_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign a_hi   = a_hi_q;
  assign ale    = ale_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;
  assign io_m   = io_m_q;
  assign busy   = busy_q;
  assign rdata  = rdata_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bus_cycle85.sv
// Directed bench for bus_cycle85: reads, writes, wait states, wait timeout,
// opcode fetch back-to-back, mid-cycle reset and the address latch pairing.
module tb_bus_cycle85;
  import bus85_pkg::*;

  localparam int WAITMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  cyc;
  logic        fetch;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        io_m;
  logic        busy;
  logic [7:0]  rdata;
  logic        done;
  logic        err;

  logic [7:0]  latch_q = 8'h00;

  int nCompared   = 0;
  int nMismatched = 0;

  int         rLat, rAle, rRdLow, rWrLow, rBadStrobe, rDataBad, rBusyGap;
  logic [7:0] rAleAd, rAleHi, rRdata;
  logic       rAleIo, rErr, rDoneAle, rDoneBusy;
  int         doneSeen;

  bus_cycle85 #(.WAITMAX(WAITMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .cyc(cyc), .fetch(fetch),
    .addr(addr), .wdata(wdata), .ready(ready), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .a_hi(a_hi), .ale(ale),
    .rd_n(rd_n), .wr_n(wr_n), .io_m(io_m), .busy(busy),
    .rdata(rdata), .done(done), .err(err)
  );

  // Free-running system clock, one T-state per period.
  always #5 clk = ~clk;

  // Transparent address latch sitting beside the sequencer at the board level.
  always @(ale or ad_out) begin
    if (ale) latch_q = ad_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] c, input logic f,
                               input logic [15:0] a, input logic [7:0] w);
    req   = r;
    cyc   = c;
    fetch = f;
    addr  = a;
    wdata = w;
  endtask

  // Steps until done, collecting per-cycle observations. readyLow is the
  // number of ready samples (end of T2, then each TW) driven low.
  task automatic runCycle(input int maxCyc, input bit holdReq, input int readyLow,
                          input logic [7:0] expW);
    bit fin;
    fin = 0;
    rLat = 0; rAle = 0; rRdLow = 0; rWrLow = 0; rBadStrobe = 0; rDataBad = 0; rBusyGap = 0;
    rAleAd = 8'hxx; rAleHi = 8'hxx; rAleIo = 1'bx;
    rRdata = 8'hxx; rErr = 1'bx; rDoneAle = 1'bx; rDoneBusy = 1'bx;
    ready = 1'b0;
    while (!fin) begin
      stepCycle();
      rLat++;
      if (!holdReq) req = 1'b0;
      if (ale && !done) begin
        rAle++;
        rAleAd = ad_out;
        rAleHi = a_hi;
        rAleIo = io_m;
      end
      if (ale && (!rd_n || !wr_n)) rBadStrobe++;
      if (!rd_n) rRdLow++;
      if (!wr_n) begin
        rWrLow++;
        if (ad_out !== expW || ad_oe !== 1'b1) rDataBad++;
      end
      if (!busy && !done) rBusyGap++;
      ready = ((rLat - 1) > readyLow);
      if (done) begin
        rRdata    = rdata;
        rErr      = err;
        rDoneAle  = ale;
        rDoneBusy = busy;
        fin = 1;
      end else if (rLat >= maxCyc) begin
        rLat = -1;
        fin = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, CYC_MR, 1'b0, 16'h0000, 8'h00);
    ready = 1'b1;
    ad_in = 8'h00;
    #2;
    checkOutput("rst_ale",   ale,    1'b0);
    checkOutput("rst_rd_n",  rd_n,   1'b1);
    checkOutput("rst_wr_n",  wr_n,   1'b1);
    checkOutput("rst_ad_oe", ad_oe,  1'b0);
    checkOutput("rst_ad_out",ad_out, 8'h00);
    checkOutput("rst_busy",  busy,   1'b0);
    checkOutput("rst_done",  done,   1'b0);
    checkOutput("rst_rdata", rdata,  8'h00);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Memory read, zero waits.
    ad_in = 8'hA5;
    applyStimulus(1'b1, CYC_MR, 1'b0, 16'h1234, 8'h00);
    runCycle(20, 1'b0, 0, 8'h00);
    checkOutput("mr_latency", rLat,       32'd4);
    checkOutput("mr_ale_cnt", rAle,       32'd1);
    checkOutput("mr_ad_lo",   rAleAd,     8'h34);
    checkOutput("mr_a_hi",    rAleHi,     8'h12);
    checkOutput("mr_io_m",    rAleIo,     1'b0);
    checkOutput("mr_rd_low",  rRdLow,     32'd2);
    checkOutput("mr_wr_low",  rWrLow,     32'd0);
    checkOutput("mr_strobe",  rBadStrobe, 32'd0);
    checkOutput("mr_rdata",   rRdata,     8'hA5);
    checkOutput("mr_err",     rErr,       1'b0);
    stepCycle();
    checkOutput("mr_done_1cyc", done, 1'b0);
    checkOutput("mr_idle",      busy, 1'b0);

    // IO write with three wait states.
    applyStimulus(1'b1, CYC_IW, 1'b0, 16'h00C0, 8'h5A);
    runCycle(40, 1'b0, 3, 8'h5A);
    checkOutput("iw_latency", rLat,     32'd7);
    checkOutput("iw_wr_low",  rWrLow,   32'd5);
    checkOutput("iw_data",    rDataBad, 32'd0);
    checkOutput("iw_ad_lo",   rAleAd,   8'hC0);
    checkOutput("iw_io_m",    rAleIo,   1'b1);
    checkOutput("iw_rd_low",  rRdLow,   32'd0);
    checkOutput("iw_err",     rErr,     1'b0);
    checkOutput("iw_rdata_keep", rRdata, 8'hA5);
    stepCycle();
    checkOutput("iw_io_hold", io_m, 1'b1);

    // Ready held low: wait limit reached.
    ad_in = 8'h3C;
    applyStimulus(1'b1, CYC_MR, 1'b0, 16'h4321, 8'h00);
    runCycle(60, 1'b0, 1000, 8'h00);
    checkOutput("to_latency", rLat,   32'(4 + WAITMAX));
    checkOutput("to_rd_low",  rRdLow, 32'(2 + WAITMAX));
    checkOutput("to_err",     rErr,   1'b1);
    checkOutput("to_rdata",   rRdata, 8'h3C);
    stepCycle();
    checkOutput("to_err_clr", err, 1'b0);
    checkOutput("to_a_hold",  a_hi, 8'h43);

    // Opcode fetch with request held: back-to-back cycles.
    ad_in = 8'h3E;
    applyStimulus(1'b1, CYC_MR, 1'b1, 16'h0000, 8'h00);
    runCycle(40, 1'b1, 0, 8'h00);
    checkOutput("of_latency",   rLat,      32'd5);
    checkOutput("of_rdata",     rRdata,    8'h3E);
    checkOutput("of_next_ale",  rDoneAle,  1'b1);
    checkOutput("of_busy_hold", rDoneBusy, 1'b1);
    checkOutput("of_busy_gap",  rBusyGap,  32'd0);
    ad_in = 8'h7F;
    runCycle(40, 1'b0, -1, 8'h00);
    checkOutput("of2_latency", rLat,   32'd4);
    checkOutput("of2_rdata",   rRdata, 8'h7F);
    checkOutput("of2_ale_cnt", rAle,   32'd0);
    stepCycle();

    // Fetch flag ignored on an IO read.
    ad_in = 8'h11;
    applyStimulus(1'b1, CYC_IR, 1'b1, 16'h8001, 8'h00);
    runCycle(20, 1'b0, 0, 8'h00);
    checkOutput("ir_no_t4", rLat,   32'd4);
    checkOutput("ir_io_m",  rAleIo, 1'b1);
    checkOutput("ir_rdata", rRdata, 8'h11);
    stepCycle();

    // Reset asserted inside a wait state.
    applyStimulus(1'b1, CYC_MR, 1'b0, 16'hBEEF, 8'h00);
    ready = 1'b0;
    stepCycle();
    req = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rs_in_tw", rd_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rs_busy",  busy,   1'b0);
    checkOutput("rs_rd_n",  rd_n,   1'b1);
    checkOutput("rs_a_hi",  a_hi,   8'h00);
    checkOutput("rs_io_m",  io_m,   1'b0);
    checkOutput("rs_rdata", rdata,  8'h00);
    checkOutput("rs_ad_out",ad_out, 8'h00);
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      if (done) doneSeen++;
    end
    rst = 1'b0;
    stepCycle();
    if (done) doneSeen++;
    checkOutput("rs_no_done", doneSeen, 32'd0);
    applyStimulus(1'b1, CYC_MW, 1'b0, 16'h2468, 8'h99);
    runCycle(20, 1'b0, 0, 8'h99);
    checkOutput("rs_after_lat",  rLat,     32'd4);
    checkOutput("rs_after_wr",   rWrLow,   32'd2);
    checkOutput("rs_after_data", rDataBad, 32'd0);
    stepCycle();

    // Address latch pairing on a memory write.
    ready = 1'b1;
    applyStimulus(1'b1, CYC_MW, 1'b0, 16'hABCD, 8'h77);
    stepCycle();
    req = 1'b0;
    checkOutput("lt_t1", latch_q, 8'hCD);
    stepCycle();
    checkOutput("lt_t2",      latch_q, 8'hCD);
    checkOutput("lt_t2_data", ad_out,  8'h77);
    stepCycle();
    checkOutput("lt_t3", latch_q, 8'hCD);
    checkOutput("lt_a_hi", a_hi, 8'hAB);
    stepCycle();
    checkOutput("lt_done", done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Hard stop in case something never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
